poly_mem_reader: RTL and testbench

Streaming read engine for the simple dual-port coefficient RAM. It owns the RAM read port (`en_b`/`addr_b`/`data_out_b`) and turns a `(base_addr, length)` command into a valid/ready stream of `length` words with a `last` marker. It absorbs the RAM's 1-cycle registered read latency and downstream back-pressure with an internal 4-entry FIFO. It feeds NTT/arith pipelines that consume polynomial coefficients.

---
 rtl/poly_mem_pkg.sv | 15 +
 rtl/poly_mem_reader_sync_fifo4.sv | 57 +++++
 rtl/poly_mem_reader.sv | 131 +++++++++++++
 tb/tb_poly_mem_reader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_mem_pkg.sv
// Shared types and constants for the coefficient-RAM stream engines.
package poly_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } rd_state_t;

  localparam int unsigned FIFO_DEPTH  = 4;
  // Max fifo_count + inflight at which another read may still issue.
  localparam int unsigned ISSUE_LIMIT = 2;

endpackage

// File: rtl/poly_mem_reader_sync_fifo4.sv
// Four-entry synchronous FIFO whose head word is held in a register.
module sync_fifo4
  import poly_mem_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [2:0]       count,
  output logic             empty
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_next;
  logic             do_pop;
  logic [2:0]       count_nx;

  always_comb begin
    do_pop   = pop && !empty;
    rd_next  = rd_ptr + PW'(1);
    count_nx = count + 3'(push) - 3'(do_pop);
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Head register: refilled from din when the queue is (becoming) empty, else from the next slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      dout   <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_next;
      count <= count_nx;
      empty <= (count_nx == 3'd0);
      if (push && (count == 3'd0 || (do_pop && count == 3'd1))) begin
        dout <= din;
      end else if (do_pop && count > 3'd1) begin
        dout <= mem[rd_next];
      end
    end
  end

endmodule

// File: rtl/poly_mem_reader.sv
// Streams `length` words starting at `base_addr` out of the coefficient RAM read port.
module poly_mem_reader
  import poly_mem_pkg::*;
#(
  parameter int unsigned MEM_WIDTH = 32,
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned LEN_W     = $clog2(MEM_DEPTH) + 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(MEM_DEPTH)-1:0] base_addr,
  input  logic [LEN_W-1:0]             length,
  output logic                         busy,
  output logic                         done,
  output logic                         en_b,
  output logic [$clog2(MEM_DEPTH)-1:0] addr_b,
  input  logic [MEM_WIDTH-1:0]         data_out_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [MEM_WIDTH-1:0]         out_data,
  output logic                         out_last
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  rd_state_t        state;
  rd_state_t        state_nx;
  logic [AW-1:0]    base_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued;
  logic [LEN_W-1:0] beats;
  logic             inflight;

  logic [2:0]       fifo_count;
  logic             fifo_empty;
  logic             pop;

  logic             start_ok;
  logic [AW-1:0]    base_eff;
  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] issued_nx;
  logic [LEN_W-1:0] beats_nx;
  logic [3:0]       count_nx;
  logic             en_b_nx;
  logic [AW-1:0]    addr_nx;
  logic             busy_nx;
  logic             done_nx;
  logic             last_nx;

  assign out_valid = !fifo_empty;
  assign pop       = !fifo_empty && out_ready;

  sync_fifo4 #(
    .WIDTH(MEM_WIDTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (inflight),
    .din  (data_out_b),
    .pop  (pop),
    .dout (out_data),
    .count(fifo_count),
    .empty(fifo_empty)
  );

  // Next state plus next-cycle values of every registered output; the credit check
  // uses the predicted FIFO occupancy and in-flight flag of the cycle being issued into.
  always_comb begin
    state_nx  = state;
    start_ok  = (state == IDLE) && start;
    base_eff  = start_ok ? base_addr : base_q;
    len_eff   = start_ok ? length : len_q;
    issued_nx = start_ok ? '0 : issued + LEN_W'(en_b);
    beats_nx  = start_ok ? '0 : beats + LEN_W'(pop);
    count_nx  = 4'(fifo_count) + 4'(inflight) - 4'(pop);

    case (state)
      IDLE: begin
        if (start) state_nx = (length == '0) ? DONE : READ;
      end
      READ: begin
        if (en_b && (issued + LEN_W'(1) == len_q)) state_nx = DRAIN;
      end
      DRAIN: begin
        if (pop && (beats == len_q - LEN_W'(1))) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    en_b_nx = (state_nx == READ) && ((count_nx + 4'(en_b)) <= 4'(ISSUE_LIMIT));
    addr_nx = en_b_nx ? (base_eff + AW'(issued_nx)) : addr_b;
    busy_nx = (state_nx == READ) || (state_nx == DRAIN);
    done_nx = (state_nx == DONE);
    last_nx = (count_nx != 4'd0) && (beats_nx == len_eff - LEN_W'(1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      issued   <= '0;
      beats    <= '0;
      inflight <= 1'b0;
      en_b     <= 1'b0;
      addr_b   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out_last <= 1'b0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        base_q <= base_addr;
        len_q  <= length;
      end
      issued   <= issued_nx;
      beats    <= beats_nx;
      inflight <= en_b;
      en_b     <= en_b_nx;
      addr_b   <= addr_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      out_last <= last_nx;
    end
  end

endmodule

// File: tb/tb_poly_mem_reader.sv
// Directed bench for poly_mem_reader with a registered-read RAM model holding ram[i]=i.
module tb_poly_mem_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] length = '0;
  logic        busy, done, en_b, out_valid, out_last;
  logic [9:0]  addr_b;
  logic [31:0] data_out_b = '0;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;

  poly_mem_reader #(
    .MEM_WIDTH(32),
    .MEM_DEPTH(1024),
    .LEN_W    (11)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .en_b      (en_b),
    .addr_b    (addr_b),
    .data_out_b(data_out_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clock = ~clock;

  logic [31:0] ram [1024];
  initial for (int i = 0; i < 1024; i++) ram[i] = 32'(i);
  always @(posedge clock) if (en_b) data_out_b <= ram[addr_b];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Occupancy model built only from observed handshakes.
  int tb_cnt  = 0;
  int tb_infl = 0;
  int viol    = 0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_data = '0;

  int   beat_q[$];
  logic last_q[$];
  int   bcyc_q[$];
  int   done_q[$];
  int   addr_q[$];

  always @(posedge clock) begin
    cyc = cyc + 1;
    if (reset) begin
      tb_cnt  = 0;
      tb_infl = 0;
    end else begin
      tb_cnt  = tb_cnt + tb_infl - ((out_valid && out_ready) ? 1 : 0);
      tb_infl = en_b ? 1 : 0;
    end
  end

  always @(negedge clock) begin
    if (!reset && cyc > 1) begin
      if (tb_cnt > 3 || (en_b && (tb_cnt + tb_infl > 2)) || (out_valid !== (tb_cnt != 0))) viol++;
      if (hold_pend && (out_valid !== 1'b1 || out_data !== hold_data)) viol++;
      if (out_valid && out_ready) begin
        beat_q.push_back(int'(out_data));
        last_q.push_back(out_last);
        bcyc_q.push_back(cyc);
      end
      if (done) done_q.push_back(cyc);
      if (en_b) addr_q.push_back(int'(addr_b));
    end
    hold_pend = out_valid && !out_ready && !reset;
    hold_data = out_data;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    beat_q.delete();
    last_q.delete();
    bcyc_q.delete();
    done_q.delete();
    addr_q.delete();
  endtask

  task automatic start_cmd(input logic [9:0] b, input logic [10:0] l, output int k);
    step();
    start = 1'b1;
    base_addr = b;
    length = l;
    step();
    start = 1'b0;
    k = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (en_b !== 1'b0) begin n_fail++; $display("FAIL reset_en_b: got %b want 0", en_b); end
    n_checks++; if (addr_b !== 10'd0) begin n_fail++; $display("FAIL reset_addr_b: got %0d want 0", addr_b); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int k, got;
    clear_logs();
    viol = 0;
    out_ready = 1'b1;
    start_cmd(10'd0, 11'd8, k);
    n_checks++; if (busy !== 1'b1 || en_b !== 1'b1 || addr_b !== 10'd0) begin
      n_fail++; $display("FAIL basic_first_issue: busy=%b en_b=%b addr=%0d want 1 1 0", busy, en_b, addr_b);
    end
    repeat (14) step();
    n_checks++; if (beat_q.size() != 8) begin n_fail++; $display("FAIL basic_beat_count: got %0d want 8", beat_q.size()); end
    for (int i = 0; i < 8; i++) begin
      got = (i < beat_q.size()) ? beat_q[i] : -1;
      n_checks++; if (got != i) begin n_fail++; $display("FAIL basic_data[%0d]: got %0d want %0d", i, got, i); end
      got = (i < bcyc_q.size()) ? bcyc_q[i] - k : -1;
      n_checks++; if (got != 2 + i) begin n_fail++; $display("FAIL basic_beat_time[%0d]: got %0d want %0d", i, got, 2 + i); end
      got = (i < last_q.size()) ? int'(last_q[i]) : -1;
      n_checks++; if (got != ((i == 7) ? 1 : 0)) begin n_fail++; $display("FAIL basic_last[%0d]: got %0d want %0d", i, got, (i == 7) ? 1 : 0); end
      got = (i < addr_q.size()) ? addr_q[i] : -1;
      n_checks++; if (got != i) begin n_fail++; $display("FAIL basic_addr[%0d]: got %0d want %0d", i, got, i); end
    end
    got = (done_q.size() == 1) ? done_q[0] - k : -1;
    n_checks++; if (got != 10) begin n_fail++; $display("FAIL basic_done: offset %0d pulses %0d want offset 10 pulses 1", got, done_q.size()); end
    n_checks++; if (viol != 0) begin n_fail++; $display("FAIL basic_flow: got %0d violations want 0", viol); end
  endtask

  task automatic test_wrap();
    int k, got;
    int exp_a [4] = '{1022, 1023, 0, 1};
    clear_logs();
    out_ready = 1'b1;
    start_cmd(10'd1022, 11'd4, k);
    repeat (10) step();
    n_checks++; if (addr_q.size() != 4 || beat_q.size() != 4) begin
      n_fail++; $display("FAIL wrap_counts: addrs %0d beats %0d want 4 4", addr_q.size(), beat_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < addr_q.size()) ? addr_q[i] : -1;
      n_checks++; if (got != exp_a[i]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, got, exp_a[i]); end
      got = (i < beat_q.size()) ? beat_q[i] : -1;
      n_checks++; if (got != exp_a[i]) begin n_fail++; $display("FAIL wrap_data[%0d]: got %0d want %0d", i, got, exp_a[i]); end
    end
    got = (last_q.size() == 4) ? int'(last_q[3]) : -1;
    n_checks++; if (got != 1) begin n_fail++; $display("FAIL wrap_last: got %0d want 1", got); end
  endtask

  task automatic test_backpressure();
    int k, got, n;
    logic [31:0] pat = 32'hB4E1_6C39;
    clear_logs();
    viol = 0;
    out_ready = 1'b0;
    start_cmd(10'd200, 11'd16, k);
    n = 0;
    while (done_q.size() == 0 && n < 300) begin
      out_ready = pat[n % 32];
      step();
      n++;
    end
    out_ready = 1'b1;
    repeat (3) step();
    n_checks++; if (done_q.size() != 1) begin n_fail++; $display("FAIL bp_done: got %0d pulses after %0d cycles want 1", done_q.size(), n); end
    n_checks++; if (beat_q.size() != 16) begin n_fail++; $display("FAIL bp_beat_count: got %0d want 16", beat_q.size()); end
    for (int i = 0; i < 16; i++) begin
      got = (i < beat_q.size()) ? beat_q[i] : -1;
      n_checks++; if (got != 200 + i) begin n_fail++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, got, 200 + i); end
      got = (i < last_q.size()) ? int'(last_q[i]) : -1;
      n_checks++; if (got != ((i == 15) ? 1 : 0)) begin n_fail++; $display("FAIL bp_last[%0d]: got %0d want %0d", i, got, (i == 15) ? 1 : 0); end
    end
    n_checks++; if (addr_q.size() != 16) begin n_fail++; $display("FAIL bp_issue_count: got %0d want 16", addr_q.size()); end
    n_checks++; if (viol != 0) begin n_fail++; $display("FAIL bp_flow: got %0d violations want 0", viol); end
  endtask

  task automatic test_len0();
    int k, got;
    int busy_hits;
    clear_logs();
    out_ready = 1'b1;
    start_cmd(10'd5, 11'd0, k);
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || en_b !== 1'b0) begin
      n_fail++; $display("FAIL len0_first: done=%b busy=%b en_b=%b want 1 0 0", done, busy, en_b);
    end
    busy_hits = 0;
    repeat (5) begin
      step();
      if (busy !== 1'b0 || out_valid !== 1'b0) busy_hits++;
    end
    n_checks++; if (busy_hits != 0) begin n_fail++; $display("FAIL len0_quiet: got %0d busy/valid cycles want 0", busy_hits); end
    got = (done_q.size() == 1) ? done_q[0] - k : -1;
    n_checks++; if (got != 0) begin n_fail++; $display("FAIL len0_done: offset %0d pulses %0d want 0 1", got, done_q.size()); end
    n_checks++; if (addr_q.size() != 0 || beat_q.size() != 0) begin
      n_fail++; $display("FAIL len0_activity: issues %0d beats %0d want 0 0", addr_q.size(), beat_q.size());
    end
  endtask

  task automatic test_ignore_start();
    int k, got;
    clear_logs();
    out_ready = 1'b1;
    start_cmd(10'd0, 11'd8, k);
    while (cyc < k + 3) step();
    start = 1'b1; base_addr = 10'd500; length = 11'd3;
    step();
    start = 1'b0;
    while (cyc < k + 10) step();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ign_done_cycle: got %b want 1", done); end
    start = 1'b1; base_addr = 10'd600; length = 11'd2;
    step();
    start = 1'b0;
    repeat (8) step();
    n_checks++; if (beat_q.size() != 8 || addr_q.size() != 8) begin
      n_fail++; $display("FAIL ign_counts: beats %0d issues %0d want 8 8", beat_q.size(), addr_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      got = (i < beat_q.size()) ? beat_q[i] : -1;
      n_checks++; if (got != i) begin n_fail++; $display("FAIL ign_data[%0d]: got %0d want %0d", i, got, i); end
    end
    n_checks++; if (done_q.size() != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ign_idle: done pulses %0d busy %b want 1 0", done_q.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    int k, got;
    clear_logs();
    out_ready = 1'b0;
    start_cmd(10'd0, 11'd32, k);
    while (cyc < k + 4) step();
    n_checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pre: out_valid=%b busy=%b want 1 1", out_valid, busy);
    end
    reset = 1'b1;
    step();
    n_checks++; if ({busy, done, en_b, out_valid, out_last} !== 5'b0) begin
      n_fail++; $display("FAIL rmid_flags: busy,done,en_b,valid,last=%b want 00000", {busy, done, en_b, out_valid, out_last});
    end
    n_checks++; if (addr_b !== 10'd0 || out_data !== 32'd0) begin
      n_fail++; $display("FAIL rmid_buses: addr_b=%0d out_data=%0h want 0 0", addr_b, out_data);
    end
    reset = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0 || en_b !== 1'b0) begin
      n_fail++; $display("FAIL rmid_discard: out_valid=%b en_b=%b want 0 0", out_valid, en_b);
    end
    clear_logs();
    out_ready = 1'b1;
    start_cmd(10'd100, 11'd2, k);
    repeat (8) step();
    n_checks++; if (beat_q.size() != 2) begin n_fail++; $display("FAIL rmid_beats: got %0d want 2", beat_q.size()); end
    for (int i = 0; i < 2; i++) begin
      got = (i < beat_q.size()) ? beat_q[i] : -1;
      n_checks++; if (got != 100 + i) begin n_fail++; $display("FAIL rmid_data[%0d]: got %0d want %0d", i, got, 100 + i); end
    end
    got = (last_q.size() == 2) ? int'({last_q[0], last_q[1]}) : -1;
    n_checks++; if (got != 1) begin n_fail++; $display("FAIL rmid_last: got %0d want 1", got); end
    n_checks++; if (done_q.size() != 1) begin n_fail++; $display("FAIL rmid_done: got %0d pulses want 1", done_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len0();
    test_ignore_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
